pipe_stage_skid: RTL
====================

Name: pipe_stage_skid

Overview:
Parametrised successor of the fixed IF/ID stage register. It is a generic pipeline-stage register with a valid/ready handshake, a 2-entry skid buffer, and stall (keep) and flush controls with selectable priority. The payload is reset or flushed to a configurable NOP, and a sideband field keeps loading through flushes. Used between any two stages (IF/ID, ID/EX, ...) so that the upstream ready path is fully registered.

Parameters:
DATA_WIDTH, 32, payload width (instruction + PC bits packed by caller)
SIDE_WIDTH, 32, sideband width (e.g. sign-extended immediate); loads even on flush
NOP_VALUE, {DATA_WIDTH{1'b0}}, payload value after reset/flush
FLUSH_OVER_KEEP, 0, 0: keep has priority over flush (legacy order); 1: flush wins
CNT_WIDTH, 16, width of the saturating flush counter

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_i  in  1  asynchronous, active-high reset
keep_i  in  1  stall: freeze all state
flush_i  in  1  discard both entries, insert NOP
in_valid_i  in  1  upstream data valid
in_ready_o  out  1  stage can accept; = ~skid_valid_q & ~keep_i
in_data_i  in  DATA_WIDTH  upstream payload
in_side_i  in  SIDE_WIDTH  upstream sideband
out_valid_o  out  1  output entry valid
out_ready_i  in  1  downstream accepts
out_data_o  out  DATA_WIDTH  output payload
out_side_o  out  SIDE_WIDTH  output sideband
occupancy_o  out  2  valid entries held (0..2)
flush_cnt_o  out  CNT_WIDTH  flushes taken, saturating

Behaviour:
- State: out entry (out_valid_q, data, side) and skid entry (skid_valid_q, data, side). Outputs are driven straight from the out entry. occupancy_o = out_valid_q + skid_valid_q.
- Reset (async, rst_i=1): out_valid=0, skid_valid=0, both data=NOP_VALUE, both side=0, flush_cnt=0. Therefore in_ready_o=1 whenever keep_i=0. A reset mid-transfer discards both entries.
- Fire events: in_fire = in_valid_i & in_ready_o; out_fire = out_valid_o & out_ready_i & ~keep_i.
- Priority per cycle, FLUSH_OVER_KEEP=0: reset > keep > flush > normal. FLUSH_OVER_KEEP=1: reset > flush > keep > normal.
- Keep taken: all registers hold; in_ready_o=0; out_valid_o unchanged; flush_i ignored and not counted.
- Flush taken:
  - out_valid=0, skid_valid=0, out data=NOP_VALUE, skid data=NOP_VALUE.
  - out side <= in_side_i, unconditionally.
  - in_fire data is dropped.
  - flush_cnt increments, saturating at all-ones.
- Normal update:
  - out entry empty or out_fire, skid valid: skid moves to out; skid_valid=0.
  - out entry empty or out_fire, skid empty, in_fire: input loads into out, out_valid=1.
  - out entry empty or out_fire, nothing to load: out_valid=0; data and side hold.
  - out entry valid and not out_fire, in_fire: input loads into skid, skid_valid=1.
- in_fire with skid valid is impossible, since in_ready_o is low.
- Latency: 1 cycle in->out when empty. Throughput: 1 transfer/cycle sustained.
- Ordering: strictly FIFO, no data loss or duplication under any out_ready_i pattern.
- in_ready_o drops the cycle after skid fills. It recovers the cycle after the skid drains; full->not-full takes 1 cycle.

Decomposition:
- Shared package pipe_pkg:
  - `WIDTH`, `ADDRWIDTH`, `OP_WIDTH`.
  - INS_NOP constant (opcode 6'b000000, 26'b0).
  - Default CNT_WIDTH.
- One sub-module pipe_entry_reg (valid+data+side register with load/clear/hold enables), instantiated twice: out and skid.
- All control logic lives in pipe_stage_skid.

Test Plan:
1. Reset, then in_valid_i=1, in_data_i=32'h2002_0005, out_ready_i=1 -> next cycle out_valid_o=1, out_data_o=32'h2002_0005, occupancy_o=1.
2. Stream A,B,C with out_ready_i=0 from the B cycle -> A held at output; B in skid; occupancy_o=2; in_ready_o=0; C not accepted. Raise out_ready_i -> A,B,C emerge in order on consecutive fires.
3. Valid out entry, flush_i=1, in_side_i=32'hFFFF_FFF0 -> out_valid_o=0, out_data_o=NOP_VALUE, out_side_o=32'hFFFF_FFF0, flush_cnt_o=1.
4. keep_i=1 and flush_i=1 together, FLUSH_OVER_KEEP=0 -> state unchanged, flush_cnt_o unchanged. Same stimulus with FLUSH_OVER_KEEP=1 -> entries cleared, flush_cnt_o incremented.
5. CNT_WIDTH=2, issue 5 flushes -> flush_cnt_o saturates at 3.
6. Skid full, assert rst_i asynchronously mid-cycle -> out_valid_o=0 and occupancy_o=0 immediately (before the clock edge); in_ready_o=1 once keep_i=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline constants and the entry-register operation encoding.
// Used by every stage register in the pipeline.
package pipe_pkg;
  localparam int WIDTH         = 32;
  localparam int ADDRWIDTH     = 32;
  localparam int OP_WIDTH      = 6;
  localparam int CNT_WIDTH_DEF = 16;

  localparam logic [WIDTH-1:0] INS_NOP = {6'b000000, 26'b0};

  typedef enum logic [1:0] {
    ENT_HOLD  = 2'd0,
    ENT_LOAD  = 2'd1,
    ENT_DRAIN = 2'd2,
    ENT_FLUSH = 2'd3
  } ent_op_e;
endpackage

// File: rtl/pipe_entry_reg.sv
// One valid+data+side register: load, drain (valid low, contents kept), flush to NOP, or hold.
// Zero added latency; the owner decides the operation every cycle.
module pipe_entry_reg
  import pipe_pkg::*;
#(
  parameter int                    DATA_WIDTH       = 32,
  parameter int                    SIDE_WIDTH       = 32,
  parameter logic [DATA_WIDTH-1:0] NOP_VALUE        = '0,
  parameter bit                    FLUSH_LOADS_SIDE = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  ent_op_e               op_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [SIDE_WIDTH-1:0] side_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [SIDE_WIDTH-1:0] side_o
);

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [SIDE_WIDTH-1:0] side_q, side_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    side_d  = side_q;
    case (op_i)
      ENT_LOAD: begin
        valid_d = 1'b1;
        data_d  = data_i;
        side_d  = side_i;
      end
      ENT_DRAIN: valid_d = 1'b0;
      ENT_FLUSH: begin
        valid_d = 1'b0;
        data_d  = NOP_VALUE;
        // the sideband keeps flowing through a flush only where the owner asks for it
        side_d  = FLUSH_LOADS_SIDE ? side_i : side_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= NOP_VALUE;
      side_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      side_q  <= side_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign side_o  = side_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with 2-entry skid, keep/flush control and a saturating flush counter.
// 1-cycle latency when empty; in_ready_o is registered (low while skid is full or keep_i is high).
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int                    DATA_WIDTH      = 32,
  parameter int                    SIDE_WIDTH      = 32,
  parameter logic [DATA_WIDTH-1:0] NOP_VALUE       = '0,
  parameter int                    FLUSH_OVER_KEEP = 0,
  parameter int                    CNT_WIDTH       = CNT_WIDTH_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  keep_i,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic [SIDE_WIDTH-1:0] in_side_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic [SIDE_WIDTH-1:0] out_side_o,
  output logic [1:0]            occupancy_o,
  output logic [CNT_WIDTH-1:0]  flush_cnt_o
);

  logic                  out_valid_q, skid_valid_q;
  logic [DATA_WIDTH-1:0] skid_data;
  logic [SIDE_WIDTH-1:0] skid_side;
  logic [CNT_WIDTH-1:0]  flush_cnt_q, flush_cnt_d;

  logic                  keep_take, flush_take, in_fire, out_fire, out_free;
  ent_op_e               out_op, skid_op;
  logic [DATA_WIDTH-1:0] out_src_data;
  logic [SIDE_WIDTH-1:0] out_src_side;

  always_comb begin
    if (FLUSH_OVER_KEEP != 0) begin
      flush_take = flush_i;
      keep_take  = keep_i & ~flush_i;
    end else begin
      keep_take  = keep_i;
      flush_take = flush_i & ~keep_i;
    end
  end

  assign in_ready_o = ~skid_valid_q & ~keep_i;
  assign in_fire    = in_valid_i & in_ready_o;
  assign out_fire   = out_valid_q & out_ready_i & ~keep_i;
  assign out_free   = ~out_valid_q | out_fire;

  always_comb begin
    out_op       = ENT_HOLD;
    skid_op      = ENT_HOLD;
    out_src_data = in_data_i;
    out_src_side = in_side_i;
    if (flush_take) begin
      out_op  = ENT_FLUSH;
      skid_op = ENT_FLUSH;
    end else if (!keep_take) begin
      if (out_free) begin
        // skid always drains first to keep FIFO order; in_fire cannot coincide with it
        if (skid_valid_q) begin
          out_op       = ENT_LOAD;
          out_src_data = skid_data;
          out_src_side = skid_side;
          skid_op      = ENT_DRAIN;
        end else if (in_fire) begin
          out_op = ENT_LOAD;
        end else begin
          out_op = ENT_DRAIN;
        end
      end else if (in_fire) begin
        skid_op = ENT_LOAD;
      end
    end
  end

  always_comb begin
    flush_cnt_d = flush_cnt_q;
    if (flush_take && !(&flush_cnt_q)) begin
      flush_cnt_d = flush_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      flush_cnt_q <= '0;
    end else begin
      flush_cnt_q <= flush_cnt_d;
    end
  end

  pipe_entry_reg #(
    .DATA_WIDTH      (DATA_WIDTH),
    .SIDE_WIDTH      (SIDE_WIDTH),
    .NOP_VALUE       (NOP_VALUE),
    .FLUSH_LOADS_SIDE(1'b1)
  ) u_out_entry (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .op_i   (out_op),
    .data_i (out_src_data),
    .side_i (out_src_side),
    .valid_o(out_valid_q),
    .data_o (out_data_o),
    .side_o (out_side_o)
  );

  pipe_entry_reg #(
    .DATA_WIDTH      (DATA_WIDTH),
    .SIDE_WIDTH      (SIDE_WIDTH),
    .NOP_VALUE       (NOP_VALUE),
    .FLUSH_LOADS_SIDE(1'b0)
  ) u_skid_entry (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .op_i   (skid_op),
    .data_i (in_data_i),
    .side_i (in_side_i),
    .valid_o(skid_valid_q),
    .data_o (skid_data),
    .side_o (skid_side)
  );

  assign out_valid_o = out_valid_q;
  assign occupancy_o = {1'b0, out_valid_q} + {1'b0, skid_valid_q};
  assign flush_cnt_o = flush_cnt_q;

endmodule
